// File: rtl/ifu_prefetch_buf.sv
// Instruction prefetch unit: owns the fetch PC, keeps up to MAX_OUTST bus reads in flight
// and buffers returned instructions in a DEPTH-entry FIFO popped by the decode stage.
module ifu_prefetch_buf #(
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       MAX_OUTST = 2,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     jump_flag_i,
  input  logic [ADDR_W-1:0]        jump_addr_i,
  input  logic                     halt_i,
  output logic                     fetch_req_o,
  output logic [ADDR_W-1:0]        fetch_addr_o,
  input  logic                     fetch_gnt_i,
  input  logic                     fetch_rvalid_i,
  input  logic [DATA_W-1:0]        fetch_rdata_i,
  output logic                     inst_valid_o,
  output logic [DATA_W-1:0]        inst_o,
  output logic [ADDR_W-1:0]        inst_addr_o,
  input  logic                     inst_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned SW = CW + 1;

  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
  localparam logic [DATA_W-1:0] NOP      = DATA_W'(32'h0000_0013);
  localparam logic [SW-1:0]     DEPTH_S  = SW'(DEPTH);
  localparam logic [OW-1:0]     MAX_O    = OW'(MAX_OUTST);
  localparam logic [OW-1:0]     O_ONE    = OW'(1);
  localparam logic [PW-1:0]     PTR_ONE  = PW'(1);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] resp_pc_q;
  logic [OW-1:0]     outst_q;
  logic [OW-1:0]     discard_q;
  logic [CW-1:0]     count_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [SW-1:0]     reserved;
  logic              issue;
  logic              grant;
  logic              resp_ok;
  logic              push;
  logic              pop;
  logic              empty;
  logic              head_valid;
  logic [OW-1:0]     outst_next;
  logic [ADDR_W-1:0] jump_tgt;

  logic unused_jump_lsb;
  assign unused_jump_lsb = ^jump_addr_i[1:0];

  always_comb begin
    jump_tgt   = {jump_addr_i[ADDR_W-1:2], 2'b00};
    // Slots already filled plus slots promised to in-flight reads; a push can never overflow.
    reserved   = SW'(count_q) + SW'(outst_q);
    issue      = rst & ~halt_i & ~jump_flag_i & (outst_q < MAX_O) & (reserved < DEPTH_S);
    grant      = issue & fetch_gnt_i;
    resp_ok    = fetch_rvalid_i & (outst_q != '0);
    push       = resp_ok & (discard_q == '0) & ~jump_flag_i;
    empty      = (count_q == '0);
    head_valid = ~empty & ~jump_flag_i;
    pop        = head_valid & inst_ready_i;
    outst_next = outst_q + OW'(grant) - OW'(resp_ok);
  end

  assign fetch_req_o  = issue;
  assign fetch_addr_o = pc_q;
  assign inst_valid_o = head_valid;
  assign inst_o       = empty ? NOP : data_mem[rd_ptr_q];
  assign inst_addr_o  = empty ? '0  : addr_mem[rd_ptr_q];
  assign count_o      = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      outst_q <= outst_next;
      if (jump_flag_i) begin
        // Every read still on the bus after this edge belongs to the old stream.
        pc_q      <= jump_tgt;
        resp_pc_q <= jump_tgt;
        discard_q <= outst_next;
        count_q   <= '0;
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
      end else begin
        if (grant) pc_q <= pc_q + PC_STEP;
        if (resp_ok && (discard_q != '0)) discard_q <= discard_q - O_ONE;
        if (push) begin
          resp_pc_q <= resp_pc_q + PC_STEP;
          wr_ptr_q  <= wr_ptr_q + PTR_ONE;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= resp_pc_q;
      data_mem[wr_ptr_q] <= fetch_rdata_i;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch_buf.sv
// Bench for ifu_prefetch_buf: queue-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ifu_prefetch_buf;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk;
  logic        rst;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        halt;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic [2:0]  count;

  ifu_prefetch_buf #(
    .DEPTH(DEPTH), .MAX_OUTST(MAXO), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag), .jump_addr_i(jump_addr), .halt_i(halt),
    .fetch_req_o(fetch_req), .fetch_addr_o(fetch_addr), .fetch_gnt_i(fetch_gnt),
    .fetch_rvalid_i(fetch_rvalid), .fetch_rdata_i(fetch_rdata),
    .inst_valid_o(inst_valid), .inst_o(inst), .inst_addr_o(inst_addr),
    .inst_ready_i(inst_ready), .count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Environment controls
  logic rv_en;
  logic inject;

  // Reference model and bus responder state
  logic [31:0] m_pc, m_rpc;
  int          m_outst, m_disc;
  logic [31:0] m_qa[$];
  logic [31:0] m_qd[$];
  logic [31:0] bus_q[$];
  logic        from_pend;
  int          grants;
  bit          e_req, e_valid, resp_ok;
  logic [31:0] e_inst, e_iaddr, tgt;

  initial begin
    fetch_rvalid = 1'b0;
    fetch_rdata  = '0;
    from_pend    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_pc = '0; m_rpc = '0; m_outst = 0; m_disc = 0;
        m_qa.delete(); m_qd.delete(); bus_q.delete();
        grants = 0;
        chk("m_rst_req",   32'(fetch_req),  0);
        chk("m_rst_addr",  fetch_addr,      0);
        chk("m_rst_valid", 32'(inst_valid), 0);
        chk("m_rst_inst",  inst,            32'h13);
        chk("m_rst_count", 32'(count),      0);
      end else begin
        e_req   = !halt && !jump_flag && (m_outst < MAXO) && (m_qa.size() + m_outst < DEPTH);
        e_valid = (m_qa.size() != 0) && !jump_flag;
        e_inst  = (m_qa.size() != 0) ? m_qd[0] : 32'h13;
        e_iaddr = (m_qa.size() != 0) ? m_qa[0] : 32'h0;
        chk("m_req",   32'(fetch_req),  32'(e_req));
        if (e_req) chk("m_addr", fetch_addr, m_pc);
        chk("m_valid", 32'(inst_valid), 32'(e_valid));
        chk("m_inst",  inst,            e_inst);
        chk("m_iaddr", inst_addr,       e_iaddr);
        chk("m_count", 32'(count),      m_qa.size());
        // advance one clock with the inputs currently applied
        resp_ok = fetch_rvalid && (m_outst > 0);
        if (fetch_rvalid && from_pend) void'(bus_q.pop_front());
        if (e_req && fetch_gnt) begin
          bus_q.push_back(m_pc);
          grants++;
        end
        if (jump_flag) begin
          m_qa.delete(); m_qd.delete();
          tgt     = {jump_addr[31:2], 2'b00};
          m_pc    = tgt;
          m_rpc   = tgt;
          m_outst = m_outst - (resp_ok ? 1 : 0);
          m_disc  = m_outst;
        end else begin
          if (e_valid && inst_ready) begin
            void'(m_qa.pop_front());
            void'(m_qd.pop_front());
          end
          if (resp_ok) begin
            if (m_disc > 0) m_disc--;
            else begin
              m_qa.push_back(m_rpc);
              m_qd.push_back(fetch_rdata);
              m_rpc = m_rpc + 32'd4;
            end
          end
          if (e_req && fetch_gnt) m_pc = m_pc + 32'd4;
          m_outst = m_outst + ((e_req && fetch_gnt) ? 1 : 0) - (resp_ok ? 1 : 0);
        end
      end
      @(posedge clk);
      #2;
      if (inject) begin
        fetch_rvalid = 1'b1; fetch_rdata = 32'hDEAD_BEEF; from_pend = 1'b0;
      end else if (rst && rv_en && bus_q.size() != 0) begin
        fetch_rvalid = 1'b1; fetch_rdata = mem_word(bus_q[0]); from_pend = 1'b1;
      end else begin
        fetch_rvalid = 1'b0; from_pend = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic g, input logic r, input logic v);
    tick();
    rst = 1'b0;
    tick();
    tick();
    gnt_set(g, r, v);
    halt = 1'b0; jump_flag = 1'b0; rst = 1'b1;
  endtask

  task automatic gnt_set(input logic g, input logic r, input logic v);
    fetch_gnt = g; inst_ready = r; rv_en = v;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!inst_valid && n < 20) begin
      tick(); #2; n++;
    end
    chk(name, 32'(inst_valid), 1);
  endtask

  logic [39:0] pg, pr, pv;

  initial begin
    rst = 1'b0; jump_flag = 1'b0; jump_addr = '0; halt = 1'b0;
    fetch_gnt = 1'b0; inst_ready = 1'b0; rv_en = 1'b0; inject = 1'b0;
    pg = 40'hF_B7DE_6F5B;
    pr = 40'hD_6BB5_9E77;
    pv = 40'hE_EDB7_76DD;

    // Reset release and streaming
    repeat (2) tick();
    gnt_set(1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    #2;
    chk("t1_req",   32'(fetch_req),  1);
    chk("t1_addr",  fetch_addr,      0);
    chk("t1_valid", 32'(inst_valid), 0);
    chk("t1_count", 32'(count),      0);
    tick(); tick(); #2;
    chk("t2_valid0", 32'(inst_valid), 1);
    chk("t2_iaddr0", inst_addr,       0);
    chk("t2_inst0",  inst,            32'h5A5A_0000);
    for (int k = 1; k < 4; k++) begin
      tick(); #2;
      chk("t2_iaddr", inst_addr, 32'(4 * k));
    end

    // Asynchronous reset mid-stream, then a stale response after release
    tick(); #2;
    rst = 1'b0;
    #1;
    chk("t6_req",   32'(fetch_req),  0);
    chk("t6_addr",  fetch_addr,      0);
    chk("t6_valid", 32'(inst_valid), 0);
    chk("t6_inst",  inst,            32'h13);
    chk("t6_iaddr", inst_addr,       0);
    chk("t6_count", 32'(count),      0);
    tick(); tick();
    rst = 1'b1; inject = 1'b1;
    #2;
    chk("t6_req_rel", 32'(fetch_req), 1);
    chk("t6_count0",  32'(count),     0);
    tick(); inject = 1'b0; #2;
    chk("t6_stale_count", 32'(count),      0);
    chk("t6_stale_valid", 32'(inst_valid), 0);
    tick(); #2;
    chk("t6_first_valid", 32'(inst_valid), 1);
    chk("t6_first_iaddr", inst_addr,       0);
    chk("t6_first_count", 32'(count),      1);

    // Backpressure fills the FIFO exactly
    do_reset(1'b1, 1'b0, 1'b1);
    repeat (8) tick();
    #2;
    chk("t3_grants", grants,          4);
    chk("t3_req",    32'(fetch_req),  0);
    chk("t3_count",  32'(count),      4);
    tick();
    inst_ready = 1'b1;
    #2;
    chk("t3_valid",  32'(inst_valid), 1);
    chk("t3_iaddr0", inst_addr,       0);
    chk("t3_req_full", 32'(fetch_req), 0);
    tick(); #2;
    chk("t3_count3", 32'(count),     3);
    chk("t3_resume", 32'(fetch_req), 1);
    chk("t3_iaddr1", inst_addr,      4);
    tick(); #2;
    chk("t3_iaddr2", inst_addr,      8);

    // Flush with two reads in flight
    do_reset(1'b1, 1'b1, 1'b0);
    tick(); tick();
    jump_addr = 32'h103; jump_flag = 1'b1;
    #2;
    chk("t4_req_jump",   32'(fetch_req),  0);
    chk("t4_valid_jump", 32'(inst_valid), 0);
    tick();
    jump_flag = 1'b0; rv_en = 1'b1;
    #2;
    chk("t4_addr", fetch_addr, 32'h100);
    wait_valid("t4_wait_valid");
    chk("t4_iaddr", inst_addr, 32'h100);
    chk("t4_inst",  inst,      mem_word(32'h100));

    // Halt with two reads in flight
    do_reset(1'b1, 1'b0, 1'b0);
    tick(); tick();
    halt = 1'b1; rv_en = 1'b1;
    #2;
    chk("t5_req_halt", 32'(fetch_req), 0);
    tick(); tick(); #2;
    chk("t5_count", 32'(count),     2);
    chk("t5_req",   32'(fetch_req), 0);
    repeat (3) tick();
    #2;
    chk("t5_grants", grants,         2);
    halt = 1'b0;
    #1;
    chk("t5_req_resume", 32'(fetch_req), 1);
    chk("t5_addr",       fetch_addr,     8);

    // Irregular grant / ready / response patterns with a flush in the middle
    for (int i = 0; i < 40; i++) begin
      tick();
      gnt_set(pg[i], pr[i], pv[i]);
      jump_flag = (i == 20);
      jump_addr = 32'h40;
    end
    tick();
    gnt_set(1'b1, 1'b1, 1'b1);
    jump_flag = 1'b0;
    repeat (6) tick();

    // Back-to-back jumps: the last target wins, and the PC wraps
    jump_flag = 1'b1; jump_addr = 32'h200;
    tick();
    jump_addr = 32'hFFFF_FFFA;
    tick();
    jump_flag = 1'b0;
    #2;
    wait_valid("t7_wait_valid");
    chk("t7_iaddr0", inst_addr, 32'hFFFF_FFF8);
    chk("t7_inst0",  inst,      mem_word(32'hFFFF_FFF8));
    tick(); #2;
    chk("t7_iaddr1", inst_addr, 32'hFFFF_FFFC);
    tick(); #2;
    chk("t7_iaddr2", inst_addr, 32'h0);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
